// File: rtl/ctrl_packet_sequencer.sv
// Host register command sequencer: issues relative-addressed control
// packets and collects absolute-addressed read responses from the return path.
module ctrl_packet_sequencer #(
    parameter int DATA_WIDTH                  = 512,
    parameter int STREAM_ID_NUM               = 16,
    parameter int CHUNK_ID_NUM                = 32,
    parameter int CHANNEL_ID_NUM              = 1024,
    parameter int STATE_WIDTH                 = 32,
    parameter int CP_A_CTRL_READ_RESPONSE_32b = 1,
    parameter int CP_R_CTRL_READ_REQUEST_32b  = 0,
    parameter int CP_R_CTRL_WRITE_32b         = 1,
    parameter int TIMEOUT_CYCLES              = 1024,
    parameter int STREAM_ID_WIDTH             = $clog2(STREAM_ID_NUM),
    parameter int CHUNK_ID_WIDTH              = $clog2(CHUNK_ID_NUM),
    parameter int CHANNEL_ID_WIDTH            = $clog2(CHANNEL_ID_NUM),
    parameter int NUM_32B_FIELDS              = DATA_WIDTH / 32
) (
    input  logic                        clk,
    input  logic                        rstnIn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [CHANNEL_ID_WIDTH-1:0] cmd_target,
    input  logic [STATE_WIDTH-1:0]      cmd_addr,
    input  logic [31:0]                 cmd_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [31:0]                 rsp_rdata,
    output logic                        rsp_error,
    output logic [DATA_WIDTH-1:0]       out_Data,
    output logic [1:0]                  out_Type,
    output logic                        out_Last,
    output logic [STREAM_ID_WIDTH-1:0]  out_StreamID,
    output logic [CHUNK_ID_WIDTH-1:0]   out_ChunkID,
    output logic [CHANNEL_ID_WIDTH-1:0] out_ChannelID,
    output logic [STATE_WIDTH-1:0]      out_State,
    input  logic [DATA_WIDTH-1:0]       ret_Data,
    input  logic [1:0]                  ret_Type,
    input  logic [CHUNK_ID_WIDTH-1:0]   ret_ChunkID,
    input  logic [STATE_WIDTH-1:0]      ret_State
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int OP_WIDTH  = CHUNK_ID_WIDTH - 1;
    localparam logic [OP_WIDTH-1:0] OP_RD  = OP_WIDTH'(CP_R_CTRL_READ_REQUEST_32b);
    localparam logic [OP_WIDTH-1:0] OP_WR  = OP_WIDTH'(CP_R_CTRL_WRITE_32b);
    localparam logic [OP_WIDTH-1:0] OP_RSP = OP_WIDTH'(CP_A_CTRL_READ_RESPONSE_32b);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESPOND} state_t;

    state_t                      state;
    state_t                      stateNext;
    logic                        armed;
    logic                        writeQ;
    logic [CHANNEL_ID_WIDTH-1:0] targetQ;
    logic [STATE_WIDTH-1:0]      addrQ;
    logic [31:0]                 wdataQ;
    logic [CNT_WIDTH-1:0]        cnt;
    logic [31:0]                 rdataQ;
    logic                        errorQ;
    logic                        accept;
    logic                        retMatch;
    logic                        expired;
    logic                        unusedRet;

    // armed keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = armed && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign expired   = (cnt == CNT_LAST);
    assign retMatch  = ret_Type[1]
                    && !ret_ChunkID[CHUNK_ID_WIDTH-1]
                    && (ret_ChunkID[OP_WIDTH-1:0] == OP_RSP)
                    && (ret_State == addrQ);
    assign unusedRet = ^{ret_Data[DATA_WIDTH-1:32], ret_Type[0]};

    assign out_Type      = (state == ISSUE) ? 2'b10 : 2'b00;
    assign out_Last      = (state == ISSUE);
    assign out_StreamID  = '0;
    assign out_ChunkID   = {1'b1, writeQ ? OP_WR : OP_RD};
    assign out_ChannelID = targetQ;
    assign out_State     = addrQ;
    assign out_Data      = writeQ ? {NUM_32B_FIELDS{wdataQ}} : '0;

    assign rsp_valid = (state == RESPOND);
    assign rsp_rdata = rdataQ;
    assign rsp_error = errorQ;

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:     if (accept) stateNext = ISSUE;
            ISSUE:    stateNext = writeQ ? RESPOND : WAIT_RSP;
            WAIT_RSP: if (retMatch || expired) stateNext = RESPOND;
            RESPOND:  if (rsp_ready) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstnIn) begin
        if (!rstnIn) begin
            state   <= IDLE;
            armed   <= 1'b0;
            writeQ  <= 1'b0;
            targetQ <= '0;
            addrQ   <= '0;
            wdataQ  <= '0;
            cnt     <= '0;
            rdataQ  <= '0;
            errorQ  <= 1'b0;
        end else begin
            state <= stateNext;
            armed <= 1'b1;
            if (accept) begin
                writeQ  <= cmd_write;
                targetQ <= cmd_target;
                addrQ   <= cmd_addr;
                wdataQ  <= cmd_wdata;
            end
            if (state == ISSUE) begin
                cnt    <= '0;
                rdataQ <= '0;
                errorQ <= 1'b0;
            end
            // a match on the expiry cycle takes priority over the timeout
            if (state == WAIT_RSP) begin
                cnt <= cnt + 1'b1;
                if (retMatch) begin
                    rdataQ <= ret_Data[31:0];
                    errorQ <= 1'b0;
                end else if (expired) begin
                    rdataQ <= '0;
                    errorQ <= 1'b1;
                end
            end
        end
    end

endmodule
